axi_port_arbiter: RTL and testbench

//  Shares the single AXI read/write master port between the fetch unit (IF) and the memory stage (MEM).

---
 rtl/axi_port_arbiter_pkg.sv | 24 ++
 rtl/axi_port_arbiter_if.sv | 55 +++++
 rtl/axi_port_arbiter_rr2.sv | 15 +
 rtl/axi_port_arbiter.sv | 135 +++++++++++++
 tb/tb_axi_port_arbiter.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/axi_port_arbiter_pkg.sv
// Shared encodings for the AXI port arbiter: request kinds, access sizes,
// FSM states and grant identifiers.
package axi_port_arbiter_pkg;

    localparam logic       REQ_READ  = 1'b0;
    localparam logic       REQ_WRITE = 1'b1;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GNT_IF  = 2'd1,
        ST_GNT_MEM = 2'd2
    } state_e;

    typedef enum logic {
        GRANT_IF  = 1'b0,
        GRANT_MEM = 1'b1
    } grant_e;

endpackage

// File: rtl/axi_port_arbiter_if.sv
// Bundle of the IF requester, MEM requester and downstream AXI port signals.
// master = the arbiter itself, slave = the requesters and downstream port.
interface axi_port_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              i_if_valid;
    logic [ADDR_W-1:0] i_if_addr;
    logic [1:0]        i_if_size;
    logic              o_if_ready;
    logic [DATA_W-1:0] o_if_data_read;
    logic [1:0]        o_if_resp;

    logic              i_mem_valid;
    logic              i_mem_req;
    logic [ADDR_W-1:0] i_mem_addr;
    logic [1:0]        i_mem_size;
    logic [DATA_W-1:0] i_mem_data_write;
    logic [7:0]        i_mem_mask;
    logic              o_mem_ready;
    logic [DATA_W-1:0] o_mem_data_read;
    logic [1:0]        o_mem_resp;

    logic              o_axi_valid;
    logic              o_axi_req;
    logic [ADDR_W-1:0] o_axi_addr;
    logic [1:0]        o_axi_size;
    logic [DATA_W-1:0] o_axi_data_write;
    logic [7:0]        o_axi_mask;
    logic              i_axi_ready;
    logic [DATA_W-1:0] i_axi_data_read;
    logic [1:0]        i_axi_resp;

    logic              o_timeout;

    modport master (
        input  i_if_valid, i_if_addr, i_if_size,
        output o_if_ready, o_if_data_read, o_if_resp,
        input  i_mem_valid, i_mem_req, i_mem_addr, i_mem_size, i_mem_data_write, i_mem_mask,
        output o_mem_ready, o_mem_data_read, o_mem_resp,
        output o_axi_valid, o_axi_req, o_axi_addr, o_axi_size, o_axi_data_write, o_axi_mask,
        input  i_axi_ready, i_axi_data_read, i_axi_resp,
        output o_timeout
    );

    modport slave (
        output i_if_valid, i_if_addr, i_if_size,
        input  o_if_ready, o_if_data_read, o_if_resp,
        output i_mem_valid, i_mem_req, i_mem_addr, i_mem_size, i_mem_data_write, i_mem_mask,
        input  o_mem_ready, o_mem_data_read, o_mem_resp,
        input  o_axi_valid, o_axi_req, o_axi_addr, o_axi_size, o_axi_data_write, o_axi_mask,
        output i_axi_ready, i_axi_data_read, i_axi_resp,
        input  o_timeout
    );
endinterface

// File: rtl/axi_port_arbiter_rr2.sv
// Two-input round-robin pick: one-hot grant from two valids and the last winner.
// Purely combinational; the caller owns the last-grant register.
module axi_port_arbiter_rr2 (
    input  logic       valid0_i,
    input  logic       valid1_i,
    input  logic       last_i,    // 1 = requester 1 won last time
    output logic [1:0] gnt_o
);
    always_comb begin
        gnt_o = 2'b00;
        if (valid0_i && valid1_i) gnt_o = last_i ? 2'b01 : 2'b10;
        else if (valid0_i)        gnt_o = 2'b01;
        else if (valid1_i)        gnt_o = 2'b10;
    end
endmodule

// File: rtl/axi_port_arbiter.sv
// Shares one AXI master port between IF (reads) and MEM (reads/writes):
// round-robin grant, request latched until the completion pulse, sticky watchdog.
module axi_port_arbiter
    import axi_port_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                i_clk,
    input  logic                i_rst,
    axi_port_arbiter_if.master  bus
);
    localparam int WD_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    state_e            state_q, state_d;
    grant_e            last_q, last_d;
    logic              valid_q, valid_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [7:0]        mask_q, mask_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              timeout_q, timeout_d;

    logic [1:0]        gnt;
    logic              if_rdy, mem_rdy;

    axi_port_arbiter_rr2 u_rr2 (
        .valid0_i (bus.i_if_valid),
        .valid1_i (bus.i_mem_valid),
        .last_i   (last_q == GRANT_MEM),
        .gnt_o    (gnt)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            last_q    <= GRANT_MEM;
            valid_q   <= 1'b0;
            req_q     <= 1'b0;
            addr_q    <= '0;
            size_q    <= '0;
            wdata_q   <= '0;
            mask_q    <= '0;
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            valid_q   <= valid_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            wdata_q   <= wdata_d;
            mask_q    <= mask_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        valid_d   = valid_q;
        req_d     = req_q;
        addr_d    = addr_q;
        size_d    = size_q;
        wdata_d   = wdata_q;
        mask_d    = mask_q;
        wd_d      = wd_q;
        timeout_d = timeout_q;
        if_rdy    = 1'b0;
        mem_rdy   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Completion pulses seen here belong to nobody and are dropped.
                if (gnt[0]) begin
                    req_d   = REQ_READ;
                    addr_d  = bus.i_if_addr;
                    size_d  = bus.i_if_size;
                    wdata_d = '0;
                    mask_d  = '0;
                    valid_d = 1'b1;
                    last_d  = GRANT_IF;
                    state_d = ST_GNT_IF;
                end else if (gnt[1]) begin
                    req_d   = bus.i_mem_req;
                    addr_d  = bus.i_mem_addr;
                    size_d  = bus.i_mem_size;
                    wdata_d = bus.i_mem_data_write;
                    mask_d  = bus.i_mem_mask;
                    valid_d = 1'b1;
                    last_d  = GRANT_MEM;
                    state_d = ST_GNT_MEM;
                end
            end
            ST_GNT_IF, ST_GNT_MEM: begin
                if (bus.i_axi_ready) begin
                    if_rdy  = (state_q == ST_GNT_IF);
                    mem_rdy = (state_q == ST_GNT_MEM);
                    valid_d = 1'b0;
                    wd_d    = '0;
                    state_d = ST_IDLE;
                end else if (TIMEOUT_CYC > 0) begin
                    // Saturate at the threshold; the flag stays set until reset.
                    if (wd_q < WD_W'(TIMEOUT_CYC))       wd_d      = wd_q + WD_W'(1);
                    if (wd_q >= WD_W'(TIMEOUT_CYC - 1))  timeout_d = 1'b1;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.o_axi_valid      = valid_q;
    assign bus.o_axi_req        = req_q;
    assign bus.o_axi_addr       = addr_q;
    assign bus.o_axi_size       = size_q;
    assign bus.o_axi_data_write = wdata_q;
    assign bus.o_axi_mask       = mask_q;
    assign bus.o_timeout        = timeout_q;

    assign bus.o_if_ready       = if_rdy;
    assign bus.o_if_data_read   = if_rdy ? bus.i_axi_data_read : '0;
    assign bus.o_if_resp        = if_rdy ? bus.i_axi_resp : 2'b00;
    assign bus.o_mem_ready      = mem_rdy;
    assign bus.o_mem_data_read  = mem_rdy ? bus.i_axi_data_read : '0;
    assign bus.o_mem_resp       = mem_rdy ? bus.i_axi_resp : 2'b00;

endmodule

// File: tb/tb_axi_port_arbiter.sv
// Directed bench for axi_port_arbiter: single requesters, alternation,
// mid-transaction input changes, watchdog and async reset.
module tb_axi_port_arbiter;
    import axi_port_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    axi_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

    axi_port_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT_CYC(8)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.master)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_if_valid = 1'b0;  bus.i_if_addr = '0; bus.i_if_size = '0;
        bus.i_mem_valid = 1'b0; bus.i_mem_req = 1'b0; bus.i_mem_addr = '0;
        bus.i_mem_size = '0;    bus.i_mem_data_write = '0; bus.i_mem_mask = '0;
        bus.i_axi_ready = 1'b0; bus.i_axi_data_read = '0; bus.i_axi_resp = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        idle_inputs();
        do_reset();
        chk("rst_valid",   64'(bus.o_axi_valid), 64'd0);
        chk("rst_addr",    bus.o_axi_addr,       64'd0);
        chk("rst_mask",    64'(bus.o_axi_mask),  64'd0);
        chk("rst_timeout", 64'(bus.o_timeout),   64'd0);

        // 1: IF read, ready three cycles after valid
        bus.i_if_valid = 1'b1; bus.i_if_addr = 64'h8000_0000; bus.i_if_size = SIZE_W;
        step();
        bus.i_if_valid = 1'b0;
        chk("t1_valid", 64'(bus.o_axi_valid), 64'd1);
        chk("t1_addr",  bus.o_axi_addr,       64'h8000_0000);
        chk("t1_req",   64'(bus.o_axi_req),   64'd0);
        chk("t1_size",  64'(bus.o_axi_size),  64'(SIZE_W));
        chk("t1_mask",  64'(bus.o_axi_mask),  64'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("t1_wait_ifrdy",  64'(bus.o_if_ready),  64'd0);
            chk("t1_wait_memrdy", 64'(bus.o_mem_ready), 64'd0);
            chk("t1_wait_valid",  64'(bus.o_axi_valid), 64'd1);
        end
        step();
        bus.i_axi_ready = 1'b1; bus.i_axi_data_read = 64'h13;
        #1;
        chk("t1_ifrdy",  64'(bus.o_if_ready),  64'd1);
        chk("t1_ifdata", bus.o_if_data_read,   64'h13);
        chk("t1_memrdy", 64'(bus.o_mem_ready), 64'd0);
        step();
        bus.i_axi_ready = 1'b0; bus.i_axi_data_read = '0;
        chk("t1_idle_valid", 64'(bus.o_axi_valid), 64'd0);
        chk("t1_idle_ifrdy", 64'(bus.o_if_ready),  64'd0);

        // ready while idle is dropped
        bus.i_axi_ready = 1'b1; bus.i_axi_data_read = 64'hFF;
        #1;
        chk("idle_rdy_if",   64'(bus.o_if_ready),  64'd0);
        chk("idle_rdy_mem",  64'(bus.o_mem_ready), 64'd0);
        chk("idle_rdy_data", bus.o_if_data_read,   64'd0);
        step();
        bus.i_axi_ready = 1'b0; bus.i_axi_data_read = '0;
        chk("idle_rdy_valid", 64'(bus.o_axi_valid), 64'd0);

        // 2: MEM write
        bus.i_mem_valid = 1'b1; bus.i_mem_req = REQ_WRITE; bus.i_mem_addr = 64'h8000_1000;
        bus.i_mem_size = SIZE_D; bus.i_mem_data_write = 64'hDEAD_BEEF; bus.i_mem_mask = 8'h0F;
        step();
        bus.i_mem_valid = 1'b0;
        chk("t2_valid", 64'(bus.o_axi_valid),  64'd1);
        chk("t2_req",   64'(bus.o_axi_req),    64'd1);
        chk("t2_mask",  64'(bus.o_axi_mask),   64'h0F);
        chk("t2_addr",  bus.o_axi_addr,        64'h8000_1000);
        chk("t2_wdata", bus.o_axi_data_write,  64'hDEAD_BEEF);
        bus.i_axi_ready = 1'b1; bus.i_axi_resp = 2'b00; bus.i_axi_data_read = 64'h55;
        #1;
        chk("t2_memrdy",  64'(bus.o_mem_ready),   64'd1);
        chk("t2_memresp", 64'(bus.o_mem_resp),    64'd0);
        chk("t2_memdata", bus.o_mem_data_read,    64'h55);
        chk("t2_ifrdy",   64'(bus.o_if_ready),    64'd0);
        step();
        idle_inputs();

        // 3: both valid from reset, instant ready -> IF, MEM, IF, MEM
        do_reset();
        bus.i_if_valid = 1'b1;  bus.i_if_addr = 64'h1000; bus.i_if_size = SIZE_W;
        bus.i_mem_valid = 1'b1; bus.i_mem_req = REQ_READ; bus.i_mem_addr = 64'h2000;
        for (int g = 0; g < 4; g++) begin
            step();
            chk("t3_valid", 64'(bus.o_axi_valid), 64'd1);
            chk("t3_addr",  bus.o_axi_addr, (g % 2 == 0) ? 64'h1000 : 64'h2000);
            bus.i_axi_ready = 1'b1; bus.i_axi_resp = 2'b01;
            #1;
            chk("t3_ifrdy",  64'(bus.o_if_ready),  (g % 2 == 0) ? 64'd1 : 64'd0);
            chk("t3_memrdy", 64'(bus.o_mem_ready), (g % 2 == 0) ? 64'd0 : 64'd1);
            step();
            bus.i_axi_ready = 1'b0;
            if (g == 3) idle_inputs();
            chk("t3_gap", 64'(bus.o_axi_valid), 64'd0);
        end

        // 4: MEM changes inputs after grant
        bus.i_mem_valid = 1'b1; bus.i_mem_req = REQ_READ; bus.i_mem_addr = 64'h3000;
        step();
        bus.i_mem_valid = 1'b0; bus.i_mem_addr = 64'h4444; bus.i_mem_req = REQ_WRITE;
        step();
        chk("t4_valid", 64'(bus.o_axi_valid), 64'd1);
        chk("t4_addr",  bus.o_axi_addr,       64'h3000);
        chk("t4_req",   64'(bus.o_axi_req),   64'd0);
        chk("t4_to",    64'(bus.o_timeout),   64'd0);
        bus.i_axi_ready = 1'b1;
        #1;
        chk("t4_memrdy", 64'(bus.o_mem_ready), 64'd1);
        step();
        idle_inputs();

        // 5: watchdog with threshold 8
        bus.i_if_valid = 1'b1; bus.i_if_addr = 64'h5000;
        step();
        bus.i_if_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            chk("t5_to_early", 64'(bus.o_timeout), 64'd0);
        end
        step();
        chk("t5_to_set", 64'(bus.o_timeout), 64'd1);
        step();
        step();
        chk("t5_still_wait", 64'(bus.o_axi_valid), 64'd1);
        bus.i_axi_ready = 1'b1;
        #1;
        chk("t5_late_rdy", 64'(bus.o_if_ready), 64'd1);
        step();
        bus.i_axi_ready = 1'b0;
        chk("t5_to_sticky", 64'(bus.o_timeout),   64'd1);
        chk("t5_idle",      64'(bus.o_axi_valid), 64'd0);
        step();
        chk("t5_to_sticky2", 64'(bus.o_timeout), 64'd1);

        // 6: async reset mid-GNT_MEM
        bus.i_mem_valid = 1'b1; bus.i_mem_addr = 64'h6000;
        step();
        bus.i_mem_valid = 1'b0;
        chk("t6_valid", 64'(bus.o_axi_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("t6_async_valid", 64'(bus.o_axi_valid), 64'd0);
        chk("t6_async_to",    64'(bus.o_timeout),   64'd0);
        step();
        rst = 1'b0;
        bus.i_if_valid = 1'b1;  bus.i_if_addr = 64'h7000;
        bus.i_mem_valid = 1'b1; bus.i_mem_addr = 64'h7100;
        step();
        idle_inputs();
        chk("t6_first_if", bus.o_axi_addr,       64'h7000);
        chk("t6_req",      64'(bus.o_axi_req),   64'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
